// File: rtl/bcd_op_sequencer.sv
// Digit-serial BCD arithmetic/bitwise sequencer for the calculator.
// One digit per clock, LSD first; negative SUB reruns with operands swapped.
module bcd_op_sequencer #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [2:0]            op,
  input  logic [4*DIGITS-1:0]   a_in,
  input  logic [4*DIGITS-1:0]   b_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  neg,
  output logic                  ovf,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_SWAP,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           cy_q, cy_d;
  logic           pass_q, pass_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [2:0]     op_q, op_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   res_q, res_d;
  logic           neg_q, neg_d;
  logic           ovf_q, ovf_d;
  logic           err_q, err_d;
  logic           busy_q, done_q;

  logic [3:0]     na, nb, dig;
  logic           cy_n;
  logic [4:0]     t5;
  logic           is_ill, is_bit, bad_in, bad_res;

  function automatic logic any_bad(input logic [W-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r = 1'b1;
    end
    return r;
  endfunction

  // The operand registers rotate right one digit per CALC edge, so the
  // current digit is always in the low nibble.
  assign na = a_q[3:0];
  assign nb = b_q[3:0];

  assign is_bit = (op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_XOR);
  assign is_ill = !(is_bit || (op_q == OP_ADD) || (op_q == OP_SUB));

  // Single-digit ALU: BCD add/sub with carry/borrow, or nibble bitwise op.
  always_comb begin
    dig  = 4'd0;
    cy_n = 1'b0;
    t5   = 5'd0;
    case (op_q)
      OP_ADD: begin
        t5 = {1'b0, na} + {1'b0, nb} + {4'd0, cy_q};
        if (t5 >= 5'd10) begin
          t5   = t5 - 5'd10;
          cy_n = 1'b1;
        end
        dig = t5[3:0];
      end
      OP_SUB: begin
        t5 = {1'b0, na} - {1'b0, nb} - {4'd0, cy_q};
        if (t5[4]) begin
          dig  = t5[3:0] + 4'd10;
          cy_n = 1'b1;
        end else begin
          dig = t5[3:0];
        end
      end
      OP_AND:  dig = na & nb;
      OP_OR:   dig = na | nb;
      OP_XOR:  dig = na ^ nb;
      default: dig = 4'd0;
    endcase
  end

  // Next-state logic: sequencing, accumulation and result/flag capture.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    pass_d  = pass_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    acc_d   = acc_q;
    res_d   = res_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    bad_in  = 1'b0;
    bad_res = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_d     = a_in;
            b_d     = b_in;
            op_d    = op;
            idx_d   = '0;
            cy_d    = 1'b0;
            pass_d  = 1'b0;
            acc_d   = '0;
            state_d = S_CALC;
          end
        end
        S_CALC: begin
          acc_d = (acc_q >> 4) | (W'(dig) << (W - 4));
          a_d   = (a_q >> 4) | (a_q << (W - 4));
          b_d   = (b_q >> 4) | (b_q << (W - 4));
          cy_d  = cy_n;
          idx_d = idx_q + 1'b1;
          if (idx_q == IW'(DIGITS - 1)) begin
            if ((op_q == OP_SUB) && !pass_q && cy_n) begin
              state_d = S_SWAP;
            end else begin
              // Nibble validity is rotation-invariant, so the
              // partly rotated operands are fine to check here.
              bad_in  = ((op_q == OP_ADD) || (op_q == OP_SUB)) &&
                        (any_bad(a_q) || any_bad(b_q));
              bad_res = is_bit && any_bad(acc_d);
              err_d   = is_ill || bad_in || bad_res;
              res_d   = (is_ill || bad_in) ? '0 : acc_d;
              ovf_d   = (op_q == OP_ADD) && cy_n;
              neg_d   = (op_q == OP_SUB) && pass_q;
              state_d = S_DONE;
            end
          end
        end
        S_SWAP: begin
          a_d     = b_q;
          b_d     = a_q;
          idx_d   = '0;
          cy_d    = 1'b0;
          pass_d  = 1'b1;
          acc_d   = '0;
          state_d = S_CALC;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      pass_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 3'd0;
      acc_q   <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      pass_q  <= pass_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_q;
  assign neg    = neg_q;
  assign ovf    = ovf_q;
  assign err    = err_q;

endmodule

// File: tb/tb_bcd_op_sequencer.sv
// Scoreboard bench for bcd_op_sequencer: directed vectors queue
// expectations; a negedge monitor checks each done pulse.
module tb_bcd_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [2:0]  op;
  logic [15:0] a_in, b_in;
  logic        busy, done, neg, ovf, err;
  logic [15:0] result;

  typedef struct {
    logic [15:0] res;
    logic        neg;
    logic        ovf;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  int          edge_cnt = 0;
  logic [15:0] last_res = 16'h0;

  bcd_op_sequencer #(.DIGITS(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .op     (op),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .neg    (neg),
    .ovf    (ovf),
    .err    (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  // Latency counts edges inclusively, from the accepting edge to the
  // edge that raised done.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got result %h, expected no done",
                 result);
      end else begin
        e = sb.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("neg", 32'(neg), 32'(e.neg));
        check("ovf", 32'(ovf), 32'(e.ovf));
        check("err", 32'(err), 32'(e.err));
        check("latency", 32'(edge_cnt - e.acc + 1), 32'(e.lat));
      end
      done_cnt++;
    end
  end

  task automatic wait_done();
    int  d0;
    bit  got;
    d0  = done_cnt;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!got) begin
        @(negedge clk);
        #1;
        if (done_cnt != d0) got = 1'b1;
      end
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL done_timeout: got no done, expected done within 40");
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] r,
                        input logic n, input logic v, input logic e,
                        input int lat);
    @(negedge clk);
    op    = o;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    sb.push_back('{r, n, v, e, lat, edge_cnt + 1});
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    wait_done();
    last_res = r;
  endtask

  initial begin
    int d_before;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    op    = 3'd0;
    a_in  = 16'h0;
    b_in  = 16'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_flags", 32'({neg, ovf, err}), 32'd0);

    // Arithmetic and bitwise vectors, issued back to back.
    run_op(3'd2, 16'h1234, 16'h5678, 16'h6912, 0, 0, 0, 5);
    run_op(3'd2, 16'h9999, 16'h0001, 16'h0000, 0, 1, 0, 5);
    run_op(3'd3, 16'h0500, 16'h0123, 16'h0377, 0, 0, 0, 5);
    run_op(3'd3, 16'h0123, 16'h0500, 16'h0377, 1, 0, 0, 10);
    run_op(3'd3, 16'h4321, 16'h4321, 16'h0000, 0, 0, 0, 5);
    run_op(3'd4, 16'h9876, 16'h5555, 16'h1054, 0, 0, 0, 5);
    run_op(3'd5, 16'h1234, 16'h0101, 16'h1335, 0, 0, 0, 5);
    run_op(3'd6, 16'h1234, 16'h5678, 16'h444C, 0, 0, 1, 5);
    run_op(3'd7, 16'h1234, 16'h5678, 16'h0000, 0, 0, 1, 5);
    run_op(3'd2, 16'h00A0, 16'h0001, 16'h0000, 0, 0, 1, 5);

    // start during CALC and during DONE is ignored.
    d_before = done_cnt;
    @(negedge clk);
    op    = 3'd2;
    a_in  = 16'h1111;
    b_in  = 16'h2222;
    start = 1'b1;
    sb.push_back('{16'h3333, 1'b0, 1'b0, 1'b0, 5, edge_cnt + 1});
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a_in  = 16'h4444;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    last_res = 16'h3333;
    start = 1'b1;
    op    = 3'd3;
    @(negedge clk);
    start = 1'b0;
    check("start_in_done_ignored", 32'(busy), 32'd0);
    repeat (8) @(negedge clk);
    check("single_done", 32'(done_cnt - d_before), 32'd1);

    // Abort mid-CALC: back to idle, no done, result held.
    d_before = done_cnt;
    @(negedge clk);
    op    = 3'd2;
    a_in  = 16'h5555;
    b_in  = 16'h1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result_held", 32'(result), 32'(last_res));
    repeat (8) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d_before), 32'd0);

    // abort wins over start in the same cycle.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort_over_start", 32'(busy), 32'd0);

    // Asynchronous reset during the second SUB pass.
    @(negedge clk);
    op    = 3'd3;
    a_in  = 16'h0123;
    b_in  = 16'h0500;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("second_pass_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_result", 32'(result), 32'd0);
    check("async_rst_flags", 32'({done, neg, ovf, err}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_idle", 32'(busy), 32'd0);
    run_op(3'd2, 16'h1234, 16'h5678, 16'h6912, 0, 0, 0, 5);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
